// File: rtl/exe_wb_stage.sv
// Execute + write-back stage: single-cycle ALU ops, multi-cycle shift-add MUL.
// Ports: clk, rst (sync, active-high); ID/EXE inputs in_valid, aluop, alusrc,
// rdata1, rdata2, sign_extend, rs1_addr, rs2_addr, waddr; stall (comb) out;
// registered write-back wb_wdata, wb_waddr, wb_wen.
// Optional macro EXE_FWD_EN enables EXE->EXE forwarding from the wb register.

`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef ASIZE
`define ASIZE 5
`endif

module exe_wb_stage (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        aluop,
  input  logic              alusrc,
  input  logic [`DSIZE-1:0] rdata1,
  input  logic [`DSIZE-1:0] rdata2,
  input  logic [`DSIZE-1:0] sign_extend,
  input  logic [`ASIZE-1:0] rs1_addr,
  input  logic [`ASIZE-1:0] rs2_addr,
  input  logic [`ASIZE-1:0] waddr,
  output logic              stall,
  output logic [`DSIZE-1:0] wb_wdata,
  output logic [`ASIZE-1:0] wb_waddr,
  output logic              wb_wen
);

  localparam int DW = `DSIZE;
  localparam int AW = `ASIZE;
  localparam int SW = $clog2(DW);
  localparam int CW = $clog2(DW + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   mul_a;
  logic [DW-1:0]   mul_b;
  logic [DW-1:0]   mul_p;
  logic [AW-1:0]   mul_waddr;

  logic [DW-1:0]   fwd1;
  logic [DW-1:0]   fwd2;
  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  logic [DW-1:0]   alu_res;
  logic            is_mul;

`ifdef EXE_FWD_EN
  assign fwd1 = (wb_wen && wb_waddr == rs1_addr)
              ? wb_wdata : rdata1;
  assign fwd2 = (wb_wen && wb_waddr == rs2_addr)
              ? wb_wdata : rdata2;
`else
  assign fwd1 = rdata1;
  assign fwd2 = rdata2;
  logic unused_addr;
  assign unused_addr = ^{rs1_addr, rs2_addr};
`endif

  // sign_extend is an immediate, never a register value, so no forwarding
  assign op_a   = fwd1;
  assign op_b   = alusrc ? sign_extend : fwd2;
  assign is_mul = (aluop == OP_MUL);

  // MUL is only accepted from IDLE; while BUSY everything upstream waits
  assign stall = (state == IDLE && in_valid && is_mul)
              || (state == BUSY);

  always_comb begin
    alu_res = '0;
    unique case (aluop)
      OP_ADD: alu_res = op_a + op_b;
      OP_SUB: alu_res = op_a - op_b;
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SLL: alu_res = op_a << op_b[SW-1:0];
      OP_SRL: alu_res = op_a >> op_b[SW-1:0];
      OP_MUL: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_p     <= '0;
      mul_waddr <= '0;
      wb_wdata  <= '0;
      wb_waddr  <= '0;
      wb_wen    <= 1'b0;
    end else begin
      wb_wen <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && is_mul) begin
            mul_a     <= op_a;
            mul_b     <= op_b;
            mul_p     <= '0;
            mul_waddr <= waddr;
            cnt       <= '0;
            state     <= BUSY;
          end else if (in_valid) begin
            wb_wdata <= alu_res;
            wb_waddr <= waddr;
            wb_wen   <= 1'b1;
          end
        end
        BUSY: begin
          // one multiplier bit per cycle, product kept to DW bits
          if (mul_b[0]) mul_p <= mul_p + mul_a;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) state <= DONE;
        end
        DONE: begin
          // the still-held MUL instruction is retired here, not re-issued
          wb_wdata <= mul_p;
          wb_waddr <= mul_waddr;
          wb_wen   <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_wb_stage.sv
// Directed testbench for exe_wb_stage (DSIZE=16, ASIZE=5).
// Inputs change 1ns after each rising edge; outputs sampled there too.

`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef ASIZE
`define ASIZE 5
`endif

module tb_exe_wb_stage;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [2:0]        aluop;
  logic              alusrc;
  logic [`DSIZE-1:0] rdata1;
  logic [`DSIZE-1:0] rdata2;
  logic [`DSIZE-1:0] sign_extend;
  logic [`ASIZE-1:0] rs1_addr;
  logic [`ASIZE-1:0] rs2_addr;
  logic [`ASIZE-1:0] waddr;
  logic              stall;
  logic [`DSIZE-1:0] wb_wdata;
  logic [`ASIZE-1:0] wb_waddr;
  logic              wb_wen;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exe_wb_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .aluop       (aluop),
    .alusrc      (alusrc),
    .rdata1      (rdata1),
    .rdata2      (rdata2),
    .sign_extend (sign_extend),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .waddr       (waddr),
    .stall       (stall),
    .wb_wdata    (wb_wdata),
    .wb_waddr    (wb_waddr),
    .wb_wen      (wb_wen)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic       v,
                       input logic [2:0] op,
                       input logic       src,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [15:0] se,
                       input logic [4:0] wa);
    in_valid    = v;
    aluop       = op;
    alusrc      = src;
    rdata1      = a;
    rdata2      = b;
    sign_extend = se;
    waddr       = wa;
  endtask

  // Presents a MUL, counts stall-high cycles (bounded) and watches wb_wen.
  task automatic run_mul(input logic [15:0] a,
                         input logic [15:0] b,
                         input logic [4:0]  wa,
                         output int         n,
                         output int         wen_seen);
    drive(1'b1, 3'b111, 1'b0, a, b, 16'h0000, wa);
    #1;
    n = 0;
    wen_seen = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      step();
      if (wb_wen === 1'b1) wen_seen++;
    end
    // held instruction stays presented in DONE, then leaves
    step();
    in_valid = 1'b0;
  endtask

  int n;
  int ws;
  int seen;

  initial begin
    rs1_addr = 5'd31;
    rs2_addr = 5'd31;
    drive(1'b0, 3'b000, 1'b0, 16'h0, 16'h0, 16'h0, 5'd0);
    rst = 1'b1;
    step();
    step();
    chk("rst_wen",   32'(wb_wen),   0);
    chk("rst_wdata", 32'(wb_wdata), 0);
    chk("rst_waddr", 32'(wb_waddr), 0);
    chk("rst_stall", 32'(stall),    0);
    rst = 1'b0;

    drive(1'b1, 3'b000, 1'b0, 16'd5, 16'd7, 16'd99, 5'd3);
    step();
    chk("add_wdata", 32'(wb_wdata), 12);
    chk("add_waddr", 32'(wb_waddr), 3);
    chk("add_wen",   32'(wb_wen),   1);

    drive(1'b1, 3'b001, 1'b1, 16'd3, 16'd99, 16'd5, 5'd6);
    step();
    chk("sub_imm", 32'(wb_wdata), 32'h0000fffe);
    chk("sub_waddr", 32'(wb_waddr), 6);

    drive(1'b1, 3'b101, 1'b1, 16'd1, 16'd0, 16'h0013, 5'd2);
    step();
    chk("sll_mask", 32'(wb_wdata), 32'h0008);

    drive(1'b1, 3'b010, 1'b0, 16'hf0f0, 16'h0ff0, 16'h0, 5'd1);
    step();
    chk("and", 32'(wb_wdata), 32'h00f0);

    drive(1'b1, 3'b011, 1'b0, 16'hf0f0, 16'h0ff0, 16'h0, 5'd1);
    step();
    chk("or", 32'(wb_wdata), 32'hfff0);

    drive(1'b1, 3'b100, 1'b0, 16'hf0f0, 16'h0ff0, 16'h0, 5'd1);
    step();
    chk("xor", 32'(wb_wdata), 32'hff00);

    drive(1'b1, 3'b110, 1'b1, 16'h8000, 16'h0, 16'h0004, 5'd1);
    step();
    chk("srl_logical", 32'(wb_wdata), 32'h0800);

    drive(1'b0, 3'b000, 1'b0, 16'h1234, 16'h4321, 16'h7, 5'd9);
    step();
    chk("idle_wen",   32'(wb_wen),   0);
    chk("idle_wdata", 32'(wb_wdata), 32'h0800);
    chk("idle_waddr", 32'(wb_waddr), 1);

    run_mul(16'h0012, 16'h0003, 5'd7, n, ws);
    chk("mul1_stall_cycles", 32'(n), 17);
    chk("mul1_no_early_wen", 32'(ws), 0);
    chk("mul1_wdata", 32'(wb_wdata), 32'h0036);
    chk("mul1_waddr", 32'(wb_waddr), 7);
    chk("mul1_wen",   32'(wb_wen),   1);
    step();
    chk("mul1_wen_one_cycle", 32'(wb_wen), 0);
    chk("mul1_stall_after",   32'(stall),  0);

    run_mul(16'h0100, 16'h0100, 5'd8, n, ws);
    chk("mul2_stall_cycles", 32'(n), 17);
    chk("mul2_wdata", 32'(wb_wdata), 32'h0000);
    chk("mul2_wen",   32'(wb_wen),   1);

    drive(1'b1, 3'b000, 1'b0, 16'd1, 16'd1, 16'h0, 5'd4);
    step();
    chk("fwd_pre", 32'(wb_wdata), 2);
    rs1_addr = 5'd4;
    drive(1'b1, 3'b000, 1'b0, 16'd0, 16'd1, 16'h0, 5'd5);
    step();
`ifdef EXE_FWD_EN
    chk("fwd_add", 32'(wb_wdata), 3);
`else
    chk("fwd_add", 32'(wb_wdata), 1);
`endif
    rs1_addr = 5'd31;

    drive(1'b1, 3'b111, 1'b0, 16'd3, 16'd5, 16'h0, 5'd9);
    #1;
    chk("mul3_stall_comb", 32'(stall), 1);
    step();
    chk("mul3_busy_stall", 32'(stall),  1);
    chk("mul3_busy_wen",   32'(wb_wen), 0);
    step();
    step();
    step();
    step();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    chk("abort_stall", 32'(stall),    0);
    chk("abort_wen",   32'(wb_wen),   0);
    chk("abort_wdata", 32'(wb_wdata), 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (wb_wen !== 1'b0 || stall !== 1'b0) seen++;
    end
    chk("abort_no_wb", 32'(seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
